// File: rtl/led_pkg.sv
// Shared 7-segment table for the LED scan encoder/decoder pair.
// Segment codes are active-low (bit set = segment dark), bit order g,f,e,d,c,b,a.
package led_pkg;

  localparam int SEG_A_BIT  = 0;
  localparam int SEG_B_BIT  = 1;
  localparam int SEG_C_BIT  = 2;
  localparam int SEG_D_BIT  = 3;
  localparam int SEG_E_BIT  = 4;
  localparam int SEG_F_BIT  = 5;
  localparam int SEG_G_BIT  = 6;
  localparam int SEG_DP_BIT = 7;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/led_seg_decode.sv
// Combinational 7-segment pattern classifier: legal hex glyph, blank, or neither.
module led_seg_decode
  import led_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] hex
);

  // Map an active-low glyph back to its hex value
  always_comb begin
    legal = 1'b1;
    blank = 1'b0;
    hex   = 4'h0;
    case (seg)
      SEG_0:     hex = 4'h0;
      SEG_1:     hex = 4'h1;
      SEG_2:     hex = 4'h2;
      SEG_3:     hex = 4'h3;
      SEG_4:     hex = 4'h4;
      SEG_5:     hex = 4'h5;
      SEG_6:     hex = 4'h6;
      SEG_7:     hex = 4'h7;
      SEG_8:     hex = 4'h8;
      SEG_9:     hex = 4'h9;
      SEG_A:     hex = 4'hA;
      SEG_B:     hex = 4'hB;
      SEG_C:     hex = 4'hC;
      SEG_D:     hex = 4'hD;
      SEG_E:     hex = 4'hE;
      SEG_F:     hex = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default: begin
        legal = 1'b0;
        blank = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/led_scan_decoder.sv
// Monitors a multiplexed active-low 7-segment bus and recovers the digit, decimal
// point and validity of every scanned position, with a per-position staleness timeout.
module led_scan_decoder
  import led_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_DIGITS-1:0]         an_n,
  input  logic [7:0]                    seg_n,
  output logic [4*NUM_DIGITS-1:0]       digits,
  output logic [NUM_DIGITS-1:0]         valid,
  output logic [NUM_DIGITS-1:0]         dp,
  output logic [NUM_DIGITS-1:0]         err,
  output logic                          update,
  output logic [$clog2(NUM_DIGITS)-1:0] update_idx
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int RUN_W = $clog2(STABLE_CYCLES + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYCLES);
  localparam logic [TO_W-1:0]  TO_MAX  = TO_W'(TIMEOUT_CYCLES);

  logic [NUM_DIGITS-1:0]            an_s1_r, an_s2_r;
  logic [7:0]                       seg_s1_r, seg_s2_r;
  logic [RUN_W-1:0]                 run_cnt_r, run_nxt_s;
  logic                             committed_r;
  logic                             same_s, qualify_s, commit_s;
  logic [NUM_DIGITS-1:0]            an_act_s;
  logic [IDX_W-1:0]                 idx_s;
  logic                             legal_s, blank_s;
  logic [3:0]                       hex_s;
  logic [NUM_DIGITS-1:0][TO_W-1:0]  to_cnt_r, to_nxt_s;
  logic [NUM_DIGITS-1:0]            hit_s, expire_s;
  logic [4*NUM_DIGITS-1:0]          digits_r;
  logic [NUM_DIGITS-1:0]            valid_r, dp_r, err_r;
  logic                             update_r;
  logic [IDX_W-1:0]                 update_idx_r;

  led_seg_decode u_seg_decode (
    .seg   (seg_s2_r[6:0]),
    .legal (legal_s),
    .blank (blank_s),
    .hex   (hex_s)
  );

  // Stability run length, anode qualification and commit decision
  always_comb begin
    same_s = (an_s1_r == an_s2_r) && (seg_s1_r == seg_s2_r);
    if (!same_s) begin
      run_nxt_s = RUN_W'(1);
    end else if (run_cnt_r == RUN_MAX) begin
      run_nxt_s = RUN_MAX;
    end else begin
      run_nxt_s = run_cnt_r + RUN_W'(1);
    end
    an_act_s  = ~an_s2_r;
    qualify_s = (an_act_s != {NUM_DIGITS{1'b0}}) &&
                ((an_act_s & (an_act_s - {{(NUM_DIGITS-1){1'b0}}, 1'b1})) == {NUM_DIGITS{1'b0}});
    idx_s = {IDX_W{1'b0}};
    for (int i = 0; i < NUM_DIGITS; i++) begin
      idx_s = idx_s | ({IDX_W{an_act_s[i]}} & IDX_W'(i));
    end
    commit_s = (run_nxt_s == RUN_MAX) && !committed_r && qualify_s;
  end

  // Per-position staleness counters; a commit restarts its position's count
  always_comb begin
    for (int i = 0; i < NUM_DIGITS; i++) begin
      hit_s[i] = commit_s && (idx_s == IDX_W'(i));
      if (hit_s[i]) begin
        to_nxt_s[i] = {TO_W{1'b0}};
      end else if (to_cnt_r[i] == TO_MAX) begin
        to_nxt_s[i] = TO_MAX;
      end else begin
        to_nxt_s[i] = to_cnt_r[i] + TO_W'(1);
      end
      expire_s[i] = (to_nxt_s[i] == TO_MAX);
    end
  end

  // Synchronisers, run tracking and the update strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_r      <= {NUM_DIGITS{1'b0}};
      an_s2_r      <= {NUM_DIGITS{1'b0}};
      seg_s1_r     <= 8'h00;
      seg_s2_r     <= 8'h00;
      run_cnt_r    <= {RUN_W{1'b0}};
      committed_r  <= 1'b0;
      update_r     <= 1'b0;
      update_idx_r <= {IDX_W{1'b0}};
    end else begin
      an_s1_r      <= an_n;
      an_s2_r      <= an_s1_r;
      seg_s1_r     <= seg_n;
      seg_s2_r     <= seg_s1_r;
      run_cnt_r    <= run_nxt_s;
      committed_r  <= same_s && (committed_r || commit_s);
      update_r     <= commit_s;
      update_idx_r <= commit_s ? idx_s : update_idx_r;
    end
  end

  // Per-position result registers; a commit takes precedence over expiry
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_r <= '0;
      digits_r <= {(4*NUM_DIGITS){1'b0}};
      valid_r  <= {NUM_DIGITS{1'b0}};
      dp_r     <= {NUM_DIGITS{1'b0}};
      err_r    <= {NUM_DIGITS{1'b0}};
    end else begin
      to_cnt_r <= to_nxt_s;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (hit_s[i]) begin
          dp_r[i]    <= ~seg_s2_r[SEG_DP_BIT];
          valid_r[i] <= legal_s;
          err_r[i]   <= !legal_s && !blank_s;
          if (legal_s) begin
            digits_r[4*i +: 4] <= hex_s;
          end
        end else if (expire_s[i]) begin
          valid_r[i] <= 1'b0;
          dp_r[i]    <= 1'b0;
        end
      end
    end
  end

  assign digits     = digits_r;
  assign valid      = valid_r;
  assign dp         = dp_r;
  assign err        = err_r;
  assign update     = update_r;
  assign update_idx = update_idx_r;

endmodule

// File: tb/tb_led_scan_decoder.sv
// Directed bench for led_scan_decoder: reset, commit latency, glitch rejection,
// illegal/blank codes, full scan and per-position timeout (TIMEOUT_CYCLES=64).
module tb_led_scan_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  an_n = 8'hFF;
  logic [7:0]  seg_n = 8'hFF;
  logic [31:0] digits;
  logic [7:0]  valid, dp, err;
  logic        update;
  logic [2:0]  update_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last0    = -1;
  int fall0    = -1;
  logic       fall_arm = 1'b0;
  logic [6:0] others_at_fall = 7'h00;

  led_scan_decoder #(.NUM_DIGITS(8), .STABLE_CYCLES(4), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst_n(rst_n), .an_n(an_n), .seg_n(seg_n),
    .digits(digits), .valid(valid), .dp(dp), .err(err),
    .update(update), .update_idx(update_idx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Track the last position-0 commit and the first fall of valid[0] once armed
  always @(negedge clk) begin
    if (update && update_idx == 3'd0) last0 = cyc;
    if (fall_arm && fall0 < 0 && !valid[0]) begin
      fall0 = cyc;
      others_at_fall = valid[7:1];
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drive pins for n cycles from a negedge; report update count, first update cycle and index
  task automatic hold(input logic [7:0] an, input logic [7:0] seg, input int n,
                      output int ups, output int first_at, output logic [2:0] idx);
    ups = 0;
    first_at = -1;
    idx = 3'd0;
    an_n = an;
    seg_n = seg;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (update) begin
        ups++;
        if (first_at < 0) first_at = i;
        idx = update_idx;
      end
    end
  endtask

  logic [7:0] scan_seg [8];
  int ups, first_at, tot;
  logic [2:0] idx;

  initial begin
    scan_seg = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h88, 8'h83, 8'hC6, 8'hA1};

    // Reset state
    repeat (3) @(negedge clk);
    check_eq("rst_digits", digits, 32'h0);
    check_eq("rst_flags", {valid, dp, err}, 32'h0);
    check_eq("rst_update", {31'h0, update}, 32'h0);

    // Basic commit: latency and decoded contents
    rst_n = 1'b1;
    hold(8'hFE, 8'hC0, 20, ups, first_at, idx);
    check_eq("basic_ups", ups, 32'd1);
    check_eq("basic_latency", first_at, 32'd5);
    check_eq("basic_idx", {29'h0, idx}, 32'd0);
    check_eq("basic_nib0", {28'h0, digits[3:0]}, 32'h0);
    check_eq("basic_flags0", {29'h0, valid[0], dp[0], err[0]}, 32'b100);

    // Reset mid-run clears everything at once
    hold(8'hFD, 8'hF9, 3, ups, first_at, idx);
    check_eq("pre_rst_ups", ups, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {24'h0, valid}, 32'h0);
    check_eq("mid_rst_digits", digits, 32'h0);
    check_eq("mid_rst_misc", {15'h0, dp, err, update}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(8'hFD, 8'hF9, 10, ups, first_at, idx);
    check_eq("post_rst_ups", ups, 32'd1);
    check_eq("post_rst_latency", first_at, 32'd5);
    check_eq("post_rst_nib1", {28'h0, digits[7:4]}, 32'h1);

    // Decimal point on the high digit F at position 3
    hold(8'hF7, 8'h0E, 10, ups, first_at, idx);
    check_eq("dp_ups", ups, 32'd1);
    check_eq("dp_idx", {29'h0, idx}, 32'd3);
    check_eq("dp_nib3", {28'h0, digits[15:12]}, 32'hF);
    check_eq("dp_flags3", {30'h0, dp[3], valid[3]}, 32'b11);

    // Glitches, anode overlap and a toggling segment bus must not commit
    hold(8'hFB, 8'hA4, 3, ups, first_at, idx);
    check_eq("short_run_ups", ups, 32'd0);
    hold(8'hFC, 8'hC0, 10, ups, first_at, idx);
    check_eq("overlap_ups", ups, 32'd0);
    tot = 0;
    for (int i = 0; i < 12; i++) begin
      hold(8'hFB, (i % 2 == 0) ? 8'hA4 : 8'hB0, 1, ups, first_at, idx);
      tot += ups;
    end
    check_eq("toggle_ups", tot, 32'd0);

    // Legal, blank and illegal codes at position 2
    hold(8'hFB, 8'hA4, 10, ups, first_at, idx);
    check_eq("pos2_legal", {22'h0, ups[0], idx, digits[11:8], valid[2], err[2]}, {22'h0, 1'b1, 3'd2, 4'h2, 1'b1, 1'b0});
    hold(8'hFB, 8'hFF, 10, ups, first_at, idx);
    check_eq("pos2_blank", {24'h0, ups[0], digits[11:8], valid[2], err[2], dp[2]}, {24'h0, 1'b1, 4'h2, 3'b000});
    hold(8'hFB, 8'h55, 10, ups, first_at, idx);
    check_eq("pos2_illegal", {24'h0, ups[0], digits[11:8], valid[2], err[2], dp[2]}, {24'h0, 1'b1, 4'h2, 3'b011});

    // Full scan of "0123ABCD", two passes
    tot = 0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int p = 0; p < 8; p++) begin
        hold(~(8'd1 << p), scan_seg[p], 8, ups, first_at, idx);
        tot += ups;
      end
    end
    check_eq("scan_ups", tot, 32'd16);
    check_eq("scan_digits", digits, 32'hDCBA_3210);
    check_eq("scan_valid", {24'h0, valid}, 32'hFF);
    check_eq("scan_err_dp", {16'h0, err, dp}, 32'h0);

    // Stop refreshing position 0; its valid must drop exactly 64 cycles after its last commit
    fall_arm = 1'b1;
    for (int pass = 0; pass < 2; pass++) begin
      for (int p = 1; p < 8; p++) begin
        hold(~(8'd1 << p), scan_seg[p], 8, ups, first_at, idx);
      end
    end
    check_eq("timeout_seen", {31'h0, fall0 >= 0}, 32'd1);
    check_eq("timeout_delay", fall0 - last0, 32'd64);
    check_eq("timeout_others", {25'h0, others_at_fall}, 32'h7F);
    check_eq("timeout_hold", {27'h0, digits[3:0], err[0]}, 32'h0);
    check_eq("timeout_end_valid", {24'h0, valid}, 32'hFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_scan_decoder.md
Name: led_scan_decoder

Overview:
- Capture side of the multiplexed common-anode 7-segment interface. It samples the active-low anode-select and segment lines of a scanned display and recovers the hex digit and decimal point shown at each position.
- Used as a display-bus monitor for self-check and loopback, and to read panels driven by external scan controllers.
- Applies input synchronisation, a stability filter, per-digit storage, pattern validation and per-digit staleness timeout.

Parameters:
- NUM_DIGITS, 8, number of scanned digit positions (an_n width).
- STABLE_CYCLES, 4, consecutive identical synchronised samples required before commit (≥2).
- TIMEOUT_CYCLES, 65536, cycles without a commit after which a digit's valid flag clears (≥2).

Ports:
- clk  in  1  single system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- an_n  in  NUM_DIGITS  digit select, active-low; bit i is position i.
- seg_n  in  8  segments, active-low; bit7=dp, bits6:0 = g,f,e,d,c,b,a.
- digits  out  4*NUM_DIGITS  recovered hex value; nibble i = position i.
- valid  out  NUM_DIGITS  position holds a decoded hex digit.
- dp  out  NUM_DIGITS  decimal point lit at position i.
- err  out  NUM_DIGITS  last committed pattern at position i was illegal.
- update  out  1  one-cycle pulse on each commit.
- update_idx  out  $clog2(NUM_DIGITS)  position committed when update=1.

Behaviour:
- Reset: one clock, asynchronous active-low reset. All outputs, synchroniser flops, counters and history clear to 0 immediately on rst_n low. This applies mid-scan and mid-count; no partial commit survives.
- Synchroniser: an_n and seg_n pass through 2-flop synchronisers (s1, s2).
- Stability counter:
  - Each edge, if s1 equals s2 (both buses), run_cnt increments, saturating at STABLE_CYCLES; otherwise run_cnt loads 1.
  - The committed flag clears whenever the samples differ.
- Qualifying sample: s2 anode has exactly one bit low. Zero or multiple low bits are blanking/overlap: run_cnt keeps counting, but no commit occurs.
- Commit: taken on the edge where run_cnt becomes STABLE_CYCLES, the sample qualifies, and committed=0. That edge sets committed=1 and registers update=1 with update_idx = low anode index.
- Latency: with pins constant from the first sampling edge, update is high after edge STABLE_CYCLES+1 (edge 5 at default) for exactly one cycle. There is one commit per stable run, however long the run is held.
- Decode of seg_n[6:0] at commit, position i:
  - 0x40→0, 0x79→1, 0x24→2, 0x30→3, 0x19→4, 0x12→5, 0x02→6, 0x78→7, 0x00→8, 0x10→9, 0x08→A, 0x03→b, 0x46→C, 0x21→d, 0x06→E, 0x0E→F.
  - Legal code: nibble i loads the value, valid[i]=1, err[i]=0.
  - 0x7F (blank): valid[i]=0, err[i]=0, nibble unchanged.
  - Any other code: valid[i]=0, err[i]=1, nibble unchanged.
  - dp[i] = ~seg_n[7] for every commit, including blank and illegal codes.
- Timeout:
  - Per-position counter clears on that position's commit and otherwise increments, saturating.
  - On reaching TIMEOUT_CYCLES it clears valid[i] and dp[i]; digits and err are held.
  - If a commit and a timeout hit the same position on the same edge, the commit wins.
- Outputs are registered and change only on clk edges or reset.

Decomposition:
- Shared package led_pkg: 7-bit active-low segment constants SEG_0..SEG_F and SEG_BLANK (0x7F), and the segment bit-index constants. The encoder and this decoder both use this table.
- Sub-module led_seg_decode: combinational, seg[6:0] → {legal, blank, hex[3:0]}. It is instantiated once on the s2 segment sample.

Test Plan:
- Reset: assert rst_n=0 mid-run with an_n=0xFE, seg_n=0xC0 held 3 cycles → all outputs 0 immediately. After release, no update until a full stable run completes.
- Basic commit: an_n=0xFE, seg_n=0xC0 held 20 cycles, default parameters → single update pulse after edge 5, update_idx=0, digits[3:0]=0, valid[0]=1, dp[0]=0, err[0]=0.
- Decimal point and high digit: an_n=0xF7, seg_n=0x0E (dp lit) held 10 cycles → update_idx=3, digits[15:12]=F, dp[3]=1, valid[3]=1.
- Glitch and overlap:
  - Value held 3 cycles then changed → no update.
  - an_n=0xFC held 10 cycles → no update.
  - seg_n toggling each cycle → no update.
- Illegal and blank codes:
  - Position 2 with seg_n=0x7F → valid[2]=0, err[2]=0, nibble unchanged.
  - Position 2 with seg_n=0x55 → err[2]=1, valid[2]=0.
- Full scan and timeout: with TIMEOUT_CYCLES=64, scan "0123ABCD" at 8 cycles/digit → all valid, digits=0xDCBA3210. Stop driving position 0 → valid[0] falls exactly 64 cycles after its last update, other positions stay valid.
